// File: rtl/apb_sram_arbiter.sv
// Two-requester round-robin APB master sharing one APB SRAM slave.
// Each transaction walks IDLE -> SETUP -> ACCESS -> DONE; all outputs are registered.
// Optional macro WAIT_TIMEOUT_EN bounds the ACCESS phase to TIMEOUT_CYCLES cycles.
module apb_sram_arbiter #(
    parameter int unsigned APB_AWIDTH     = 20,
    parameter int unsigned APB_DWIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETN,
    input  logic                  REQ0,
    input  logic                  WR0,
    input  logic [APB_AWIDTH-1:0] ADDR0,
    input  logic [APB_DWIDTH-1:0] WDATA0,
    input  logic                  REQ1,
    input  logic                  WR1,
    input  logic [APB_AWIDTH-1:0] ADDR1,
    input  logic [APB_DWIDTH-1:0] WDATA1,
    output logic                  ACK0,
    output logic [APB_DWIDTH-1:0] RDATA0,
    output logic                  ERR0,
    output logic                  ACK1,
    output logic [APB_DWIDTH-1:0] RDATA1,
    output logic                  ERR1,
    output logic                  GNT_ID,
    output logic                  BUSY,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [APB_AWIDTH-1:0] PADDR,
    output logic [APB_DWIDTH-1:0] PWDATA,
    input  logic [APB_DWIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    // Elaboration-time parameter sanity checks
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("apb_sram_arbiter: TIMEOUT_CYCLES must be in 2..255");
    end
    if (APB_DWIDTH != 8 && APB_DWIDTH != 16 && APB_DWIDTH != 32) begin : g_bad_dwidth
        $error("apb_sram_arbiter: APB_DWIDTH must be 8, 16 or 32");
    end

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StDone} state_t;

    state_t state;
    logic   rr_ptr;   // requester favoured when both request
    logic   pick;

`ifdef WAIT_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] tmo_cnt;
`endif

    // Winner selection: a lone request wins outright, a tie goes to the pointer
    assign pick = (REQ0 && REQ1) ? rr_ptr : REQ1;

    // Arbitration FSM with registered APB and requester-side outputs
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state   <= StIdle;
            rr_ptr  <= 1'b0;
            GNT_ID  <= 1'b0;
            BUSY    <= 1'b0;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
            PADDR   <= '0;
            PWDATA  <= '0;
            ACK0    <= 1'b0;
            ACK1    <= 1'b0;
            ERR0    <= 1'b0;
            ERR1    <= 1'b0;
            RDATA0  <= '0;
            RDATA1  <= '0;
`ifdef WAIT_TIMEOUT_EN
            tmo_cnt <= 8'd0;
`endif
        end else begin
            ACK0 <= 1'b0;
            ACK1 <= 1'b0;
            case (state)
                StIdle: begin
                    if (REQ0 || REQ1) begin
                        GNT_ID <= pick;
                        PWRITE <= pick ? WR1 : WR0;
                        PADDR  <= pick ? ADDR1 : ADDR0;
                        PWDATA <= pick ? WDATA1 : WDATA0;
                        PSEL   <= 1'b1;
                        BUSY   <= 1'b1;
                        state  <= StSetup;
                    end
                end
                StSetup: begin
                    PENABLE <= 1'b1;
`ifdef WAIT_TIMEOUT_EN
                    tmo_cnt <= 8'd0;
`endif
                    state   <= StAccess;
                end
                StAccess: begin
                    if (PREADY) begin
                        PSEL    <= 1'b0;
                        PENABLE <= 1'b0;
                        state   <= StDone;
                        if (GNT_ID) begin
                            ACK1 <= 1'b1;
                            ERR1 <= PSLVERR;
                            if (!PWRITE) RDATA1 <= PRDATA;
                        end else begin
                            ACK0 <= 1'b1;
                            ERR0 <= PSLVERR;
                            if (!PWRITE) RDATA0 <= PRDATA;
                        end
`ifdef WAIT_TIMEOUT_EN
                    end else if (tmo_cnt == TMO_LAST) begin
                        // Abort: report an error and return zero read data
                        PSEL    <= 1'b0;
                        PENABLE <= 1'b0;
                        state   <= StDone;
                        if (GNT_ID) begin
                            ACK1 <= 1'b1;
                            ERR1 <= 1'b1;
                            if (!PWRITE) RDATA1 <= '0;
                        end else begin
                            ACK0 <= 1'b1;
                            ERR0 <= 1'b1;
                            if (!PWRITE) RDATA0 <= '0;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
`endif
                    end
                end
                StDone: begin
                    // Error status is only meaningful alongside the ACK pulse
                    ERR0   <= 1'b0;
                    ERR1   <= 1'b0;
                    BUSY   <= 1'b0;
                    rr_ptr <= ~GNT_ID;
                    state  <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
